// File: rtl/mips_pkg.sv
// Shared MIPS definitions: opcodes, data-memory FSM state encoding and request payload.
package mips_pkg;

  localparam int unsigned WORD_W = 32;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_t;

  typedef struct packed {
    logic              write;
    logic [WORD_W-1:0] addr;
    logic [WORD_W-1:0] wdata;
  } dmem_req_t;

endpackage

// File: rtl/dmem_responder_if.sv
// Core <-> data-memory request/response bundle.
interface dmem_responder_if;
  import mips_pkg::*;

  logic              req_valid;
  logic              req_write;
  logic [WORD_W-1:0] req_addr;
  logic [WORD_W-1:0] req_wdata;
  logic              req_ready;
  logic              resp_valid;
  logic [WORD_W-1:0] resp_rdata;
  logic              resp_err;
  logic              stall;

  modport master (
    output req_valid, req_write, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err, stall
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err, stall
  );

endinterface

// File: rtl/dmem_array.sv
// Single-port DEPTH_WORDS x 32 data RAM: synchronous write, registered read, no reset.
module dmem_array
  import mips_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 256,
  localparam int unsigned AW = $clog2(DEPTH_WORDS)
) (
  input  logic              clk,
  input  logic              we,
  input  logic              re,
  input  logic [AW-1:0]     addr,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem_q [DEPTH_WORDS];
  logic [WORD_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) mem_q[addr] <= wdata;
    if (re) rdata_q <= mem_q[addr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one load/store, inserts WAIT_STATES cycles, then
// pulses a response while stalling the core for the duration of the access.
module dmem_responder
  import mips_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned WAIT_STATES = 1,
  parameter int unsigned CNT_W       = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  dmem_responder_if.slave  bus
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);

  dmem_state_t       state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  dmem_req_t         req_q, req_d;
  logic              ready_q, ready_d;
  logic              rvalid_q, rvalid_d;
  logic              err_q, err_d;
  logic              rd_en_q, rd_en_d;

  dmem_req_t         live_req;
  dmem_req_t         cmt_req;
  logic              commit;
  logic              cmt_err;
  logic              mem_we;
  logic              mem_re;
  logic [WORD_W-1:0] mem_rdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      req_q    <= '0;
      ready_q  <= 1'b1;
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
      rd_en_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      req_q    <= req_d;
      ready_q  <= ready_d;
      rvalid_q <= rvalid_d;
      err_q    <= err_d;
      rd_en_q  <= rd_en_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    req_d    = req_q;
    commit   = 1'b0;
    live_req = '{write: bus.req_write, addr: bus.req_addr, wdata: bus.req_wdata};

    case (state_q)
      IDLE: begin
        if (bus.req_valid && ready_q) begin
          req_d = live_req;
          if (WAIT_STATES == 0) begin
            state_d = RESP;
            commit  = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_W'(WAIT_STATES - 1);
          end
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d = RESP;
          commit  = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // A zero-wait access commits straight from the live request fields
    cmt_req = (state_q == IDLE) ? live_req : req_q;
    cmt_err = (cmt_req.addr[1:0] != 2'b00) ||
              (cmt_req.addr[WORD_W-1:2] >= 30'(DEPTH_WORDS));

    // rst_n gate keeps a held-reset clock edge from writing the array
    mem_we   = commit && cmt_req.write && !cmt_err && rst_n;
    mem_re   = commit && !cmt_req.write && !cmt_err;

    ready_d  = (state_d == IDLE);
    rvalid_d = commit;
    err_d    = commit && cmt_err;
    rd_en_d  = mem_re;
  end

  dmem_array #(
    .DEPTH_WORDS (DEPTH_WORDS)
  ) u_array (
    .clk   (clk),
    .we    (mem_we),
    .re    (mem_re),
    .addr  (cmt_req.addr[AW+1:2]),
    .wdata (cmt_req.wdata),
    .rdata (mem_rdata)
  );

  assign bus.req_ready  = ready_q;
  assign bus.resp_valid = rvalid_q;
  assign bus.resp_err   = err_q;
  // Read data is forced to zero except on a good load response
  assign bus.resp_rdata = rd_en_q ? mem_rdata : '0;
  assign bus.stall      = (state_q == WAIT) || ((state_q == IDLE) && bus.req_valid);

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: three instances (WAIT_STATES = 2, 0, 3).
module tb_dmem_responder;

  typedef struct packed {
    logic [1:0]  k;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic              clk = 1'b0;
  logic [2:0]        rst_n_v;
  logic [2:0]        req_valid, req_write;
  logic [2:0][31:0]  req_addr, req_wdata;
  logic [2:0]        ready_o, rv_o, err_o, stall_o;
  logic [2:0][31:0]  rdata_o;

  int                total = 0;
  int                bad = 0;
  int                last_lat, last_stall;
  exp_t              exp_q[$];
  exp_t              mon_e;
  logic [31:0]       ref_mem [3][256];

  always #5 clk = ~clk;

  genvar g;
  for (g = 0; g < 3; g++) begin : g_dut
    localparam int unsigned WS = (g == 0) ? 2 : ((g == 1) ? 0 : 3);
    dmem_responder_if bus ();
    assign bus.req_valid = req_valid[g];
    assign bus.req_write = req_write[g];
    assign bus.req_addr  = req_addr[g];
    assign bus.req_wdata = req_wdata[g];
    assign ready_o[g]    = bus.req_ready;
    assign rv_o[g]       = bus.resp_valid;
    assign rdata_o[g]    = bus.resp_rdata;
    assign err_o[g]      = bus.resp_err;
    assign stall_o[g]    = bus.stall;

    dmem_responder #(
      .DEPTH_WORDS (256),
      .WAIT_STATES (WS),
      .CNT_W       (4)
    ) u_dut (
      .clk   (clk),
      .rst_n (rst_n_v[g]),
      .bus   (bus)
    );
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic exp_t predict(input int k, input logic wr, input logic [31:0] a);
    exp_t e;
    e.k     = 2'(k);
    e.err   = (a[1:0] != 2'b00) || (a[31:2] >= 30'd256);
    e.rdata = (wr || e.err) ? 32'h0 : ref_mem[k][a[9:2]];
    return e;
  endfunction

  // One access: push the expected response, hold req_valid until accepted, then
  // measure latency (negedges until resp_valid) and stall cycles.
  task automatic access(input int k, input logic wr, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] er, input logic ee);
    exp_t e;
    int   n;
    @(negedge clk);
    req_valid[k] = 1'b1;
    req_write[k] = wr;
    req_addr[k]  = a;
    req_wdata[k] = wd;
    e.k = 2'(k); e.rdata = er; e.err = ee;
    exp_q.push_back(e);
    if (wr && !ee) ref_mem[k][a[9:2]] = wd;
    last_lat = 0; last_stall = 0; n = 0;
    #1;
    while (!ready_o[k] && n < 20) begin
      @(negedge clk); #1; n++;
    end
    chk("ready_seen", 32'(ready_o[k]), 32'd1);
    if (stall_o[k]) last_stall++;
    @(posedge clk); #1;
    req_valid[k] = 1'b0;
    do begin
      @(negedge clk); #1;
      last_lat++;
      if (stall_o[k]) last_stall++;
      if (!rv_o[k]) chk("ready_busy", 32'(ready_o[k]), 32'd0);
    end while (!rv_o[k] && last_lat < 40);
    chk("resp_seen", 32'(rv_o[k]), 32'd1);
  endtask

  // Monitor: every response pops the scoreboard; quiet outputs must stay zero.
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (rv_o[k]) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_resp", 32'(k), 32'hFFFF_FFFF);
        end else begin
          mon_e = exp_q.pop_front();
          chk("resp_dut", 32'(k), 32'(mon_e.k));
          chk("resp_rdata", rdata_o[k], mon_e.rdata);
          chk("resp_err", 32'(err_o[k]), 32'(mon_e.err));
        end
        chk("stall_in_resp", 32'(stall_o[k]), 32'd0);
        chk("ready_in_resp", 32'(ready_o[k]), 32'd0);
      end else begin
        chk("quiet_rdata", rdata_o[k], 32'h0);
        chk("quiet_err", 32'(err_o[k]), 32'd0);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    exp_t e;
    logic [31:0] a, wd;
    logic        wr;
    int          r;

    rst_n_v   = 3'b111;
    req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
    #1 rst_n_v = 3'b000;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ready", 32'(ready_o), 32'h7);
    chk("reset_rvalid", 32'(rv_o), 32'h0);
    chk("reset_err", 32'(err_o), 32'h0);
    chk("reset_stall", 32'(stall_o), 32'h0);
    for (int k = 0; k < 3; k++) chk("reset_rdata", rdata_o[k], 32'h0);
    @(negedge clk);
    rst_n_v = 3'b111;

    // Instance 0 (2 wait states): fill words 0..63 with a known pattern
    for (int i = 0; i < 64; i++) access(0, 1'b1, 32'(i * 4), 32'hA500_0000 | 32'(i), 32'h0, 1'b0);

    access(0, 1'b1, 32'h10, 32'hDEAD_BEEF, 32'h0, 1'b0);
    chk("ws2_store_lat", 32'(last_lat), 32'd3);
    chk("ws2_store_stall", 32'(last_stall), 32'd3);
    access(0, 1'b0, 32'h10, 32'h0, 32'hDEAD_BEEF, 1'b0);
    chk("ws2_load_lat", 32'(last_lat), 32'd3);
    chk("ws2_load_stall", 32'(last_stall), 32'd3);
    access(0, 1'b0, 32'h13, 32'h0, 32'h0, 1'b1);
    access(0, 1'b1, 32'h400, 32'hBAD0_BAD0, 32'h0, 1'b1);
    access(0, 1'b0, 32'h0, 32'h0, 32'hA500_0000, 1'b0);

    // Random mix against the reference model
    for (int i = 0; i < 1000; i++) begin
      r  = int'($urandom_range(0, 99));
      wr = 1'($urandom_range(0, 1));
      wd = $urandom;
      if (r < 8)       a = 32'($urandom_range(0, 63) * 4) | 32'($urandom_range(1, 3));
      else if (r < 14) a = ($urandom | 32'h400) & 32'hFFFF_FFFC;
      else             a = 32'($urandom_range(0, 63) * 4);
      e = predict(0, wr, a);
      access(0, wr, a, wd, e.rdata, e.err);
      chk("rand_lat", 32'(last_lat), 32'd3);
    end

    // Instance 1 (0 wait states): single store then back-to-back loads
    access(1, 1'b1, 32'h8, 32'hCAFE_F00D, 32'h0, 1'b0);
    chk("ws0_store_lat", 32'(last_lat), 32'd1);
    chk("ws0_store_stall", 32'(last_stall), 32'd1);
    @(negedge clk);
    req_valid[1] = 1'b1; req_write[1] = 1'b0; req_addr[1] = 32'h8; req_wdata[1] = 32'h0;
    e.k = 2'd1; e.rdata = 32'hCAFE_F00D; e.err = 1'b0;
    for (int i = 0; i < 4; i++) exp_q.push_back(e);
    for (int i = 0; i < 8; i++) begin
      #1 chk("b2b_ready", 32'(ready_o[1]), (i % 2 == 0) ? 32'd1 : 32'd0);
      @(negedge clk);
    end
    req_valid[1] = 1'b0;
    repeat (4) @(negedge clk);
    chk("b2b_drained", 32'(exp_q.size()), 32'd0);

    // Instance 2 (3 wait states): reset during the second WAIT cycle aborts a store
    access(2, 1'b1, 32'h20, 32'hAAAA_5555, 32'h0, 1'b0);
    chk("ws3_store_lat", 32'(last_lat), 32'd4);
    @(negedge clk);
    req_valid[2] = 1'b1; req_write[2] = 1'b1; req_addr[2] = 32'h20; req_wdata[2] = 32'h1234_5678;
    @(posedge clk); #1;
    req_valid[2] = 1'b0;
    @(posedge clk); #1;
    chk("abort_stall_before", 32'(stall_o[2]), 32'd1);
    #1 rst_n_v[2] = 1'b0;
    #1;
    chk("abort_ready", 32'(ready_o[2]), 32'd1);
    chk("abort_rvalid", 32'(rv_o[2]), 32'd0);
    chk("abort_err", 32'(err_o[2]), 32'd0);
    chk("abort_rdata", rdata_o[2], 32'h0);
    chk("abort_stall", 32'(stall_o[2]), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n_v[2] = 1'b1;
    repeat (8) @(negedge clk);
    chk("abort_no_resp", 32'(exp_q.size()), 32'd0);
    access(2, 1'b0, 32'h20, 32'h0, 32'hAAAA_5555, 1'b0);

    repeat (3) @(negedge clk);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
